// File: rtl/fifo_ram.sv
// Purpose     : single-clock FIFO on an inferred block-RAM array with level, threshold and sticky error flags.
// Latency     : standard mode q/rvalid two edges after an accepted read; show-ahead head word visible two edges after its write.
// Backpressure: wr ignored while full (sets overflow), rd ignored while empty (sets underflow); flush beats wr/rd.
//
// Build option: define FIFO_SHOWAHEAD_EN for first-word-fall-through (q valid whenever !empty, rd pops).
// Ports: clock, reset_n (async, active-low), flush (sync clear), wr/data (push), rd (read or pop),
//        q/rvalid (read data), empty/full/almost_full/almost_empty/level (occupancy), overflow/underflow (sticky).
module fifo_ram #(
  parameter int width    = 8,
  parameter int widthad  = 10,
  parameter int af_level = 2**widthad - 4,
  parameter int ae_level = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               wr,
  input  logic [width-1:0]   data,
  input  logic               rd,
  output logic [width-1:0]   q,
  output logic               rvalid,
  output logic               empty,
  output logic               full,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [widthad:0]   level,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [widthad:0] capacity = {1'b1, {widthad{1'b0}}};
  localparam logic [widthad:0] af_thr   = (widthad+1)'(af_level);
  localparam logic [widthad:0] ae_thr   = (widthad+1)'(ae_level);
  localparam logic [widthad:0] one      = (widthad+1)'(1);

  logic [width-1:0]   mem [0:(2**widthad)-1];
  logic [widthad-1:0] wptr;
  logic [widthad-1:0] rptr;
  logic               wr_acc;
  logic               rd_acc;
  logic [widthad:0]   level_nxt;

  // full/empty are registered, so acceptance never depends on same-cycle traffic
  assign wr_acc = wr && !full && !flush;
  assign rd_acc = rd && !empty && !flush;

  always_comb begin
    level_nxt = level;
    if (wr_acc && !rd_acc)
      level_nxt = level + one;
    else if (rd_acc && !wr_acc)
      level_nxt = level - one;
  end

  always_ff @(posedge clock) begin
    if (wr_acc)
      mem[wptr] <= data;
  end

  // occupancy, thresholds and sticky error flags (shared by both read modes)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr         <= '0;
      level        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      wptr         <= '0;
      level        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc)
        wptr <= wptr + 1'b1;
      level        <= level_nxt;
      full         <= (level_nxt == capacity);
      almost_full  <= (level_nxt >= af_thr);
      almost_empty <= (level_nxt <= ae_thr);
      if (wr && full)
        overflow <= 1'b1;
      if (rd && empty)
        underflow <= 1'b1;
    end
  end

`ifdef FIFO_SHOWAHEAD_EN
  // Two-stage read path: RAM output register (s1) feeding the prefetch register q.
  // ram_cnt counts words sitting in the array that have not been fetched yet.
  logic [widthad:0] ram_cnt;
  logic [widthad:0] ram_cnt_nxt;
  logic             s1_vld;
  logic [width-1:0] s1_q;
  logic             out_free;
  logic             s1_move;
  logic             fetch;

  assign out_free = empty || rd_acc;
  assign s1_move  = s1_vld && out_free;
  // ram_cnt only covers completed writes, so a fetch never hits the slot being written
  assign fetch    = (ram_cnt != '0) && (!s1_vld || out_free);
  assign rvalid   = !empty;

  always_comb begin
    ram_cnt_nxt = ram_cnt;
    if (wr_acc && !fetch)
      ram_cnt_nxt = ram_cnt + one;
    else if (fetch && !wr_acc)
      ram_cnt_nxt = ram_cnt - one;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rptr    <= '0;
      ram_cnt <= '0;
      s1_vld  <= 1'b0;
      s1_q    <= '0;
      q       <= '0;
      empty   <= 1'b1;
    end else if (flush) begin
      rptr    <= '0;
      ram_cnt <= '0;
      s1_vld  <= 1'b0;
      empty   <= 1'b1;
    end else begin
      ram_cnt <= ram_cnt_nxt;
      if (fetch) begin
        s1_q <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      s1_vld <= fetch || (s1_vld && !s1_move);
      if (s1_move) begin
        q     <= s1_q;
        empty <= 1'b0;
      end else if (rd_acc) begin
        empty <= 1'b1;
      end
    end
  end
`else
  // avail counts words readable next edge; it trails writes by one edge so a
  // read never targets the slot written in the same cycle.
  logic [widthad:0] avail;
  logic [widthad:0] avail_nxt;
  logic             wr_acc_d;
  logic             rd_d;
  logic [width-1:0] ram_q;

  always_comb begin
    avail_nxt = avail;
    if (wr_acc_d && !rd_acc)
      avail_nxt = avail + one;
    else if (rd_acc && !wr_acc_d)
      avail_nxt = avail - one;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rptr     <= '0;
      avail    <= '0;
      wr_acc_d <= 1'b0;
      rd_d     <= 1'b0;
      ram_q    <= '0;
      q        <= '0;
      rvalid   <= 1'b0;
      empty    <= 1'b1;
    end else if (flush) begin
      rptr     <= '0;
      avail    <= '0;
      wr_acc_d <= 1'b0;
      rd_d     <= 1'b0;
      rvalid   <= 1'b0;
      empty    <= 1'b1;
    end else begin
      wr_acc_d <= wr_acc;
      avail    <= avail_nxt;
      empty    <= (avail_nxt == '0);
      rd_d     <= rd_acc;
      rvalid   <= rd_d;
      if (rd_acc) begin
        ram_q <= mem[rptr];
        rptr  <= rptr + 1'b1;
      end
      // q holds its last word between reads
      if (rd_d)
        q <= ram_q;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ram.sv
module tb_fifo_ram;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;
`ifdef FIFO_SHOWAHEAD_EN
  localparam int LAT = 3;   // edges from accepted write to first edge a rd can pop it
`else
  localparam int LAT = 2;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       flush = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] q;
  logic       rvalid, empty, full, almost_full, almost_empty, overflow, underflow;
  logic [4:0] level;

  fifo_ram #(.width(8), .widthad(4), .af_level(AF), .ae_level(AE)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .wr(wr), .data(data), .rd(rd),
    .q(q), .rvalid(rvalid), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // Reference model: queue of accepted words tagged with the edge they were written on.
  typedef struct { logic [7:0] d; int t; } ent_t;
  ent_t       mq[$];
  logic [7:0] sb[$];   // words expected on q, in order
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  ovf_m = 0, unf_m = 0, racc_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit head_vis(input int e);
    return (mq.size() > 0) && (mq[0].t + LAT <= e);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_q"}, q, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_almost_full"}, almost_full, 0);
    chk({tag, "_almost_empty"}, almost_empty, 1);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_underflow"}, underflow, 0);
  endtask

  task automatic chk_state(input bit rv_exp);
    chk("level", level, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("almost_full", almost_full, mq.size() >= AF);
    chk("almost_empty", almost_empty, mq.size() <= AE);
    chk("empty", empty, !head_vis(cyc + 1));
    chk("overflow", overflow, ovf_m);
    chk("underflow", underflow, unf_m);
`ifdef FIFO_SHOWAHEAD_EN
    chk("rvalid", rvalid, head_vis(cyc + 1));
`else
    chk("rvalid", rvalid, rv_exp);
`endif
  endtask

  // Drive one cycle (inputs set 1ns after an edge), then update the model and check.
  task automatic step(input bit w, input bit r, input bit f, input logic [7:0] d);
    bit full_m, vis, wacc, racc;
    wr = w; rd = r; flush = f; data = d;
    @(posedge clock);
    cyc++;
    #1;
    racc = 0;
    if (f) begin
      mq.delete(); sb.delete();
      ovf_m = 0; unf_m = 0;
    end else begin
      full_m = (mq.size() == DEPTH);
      vis    = head_vis(cyc);
      wacc   = w && !full_m;
      racc   = r && vis;
      if (w && full_m) ovf_m = 1;
      if (r && !vis)   unf_m = 1;
      if (racc) begin
        sb.push_back(mq[0].d);
        void'(mq.pop_front());
      end
      if (wacc) mq.push_back('{d, cyc});
    end
    chk_state(racc_prev && !f);
    racc_prev = racc;
    wr = 0; rd = 0; flush = 0;
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge.
  task automatic do_reset();
    #2 reset_n = 0;
    #1 chk_reset("midrst");
    @(posedge clock);
    cyc++;
    #1;
    reset_n = 1;
    mq.delete(); sb.delete();
    ovf_m = 0; unf_m = 0; racc_prev = 0;
    chk_reset("postrst");
  endtask

  // Output monitor: consumes the scoreboard whenever the DUT presents a word.
  initial begin
    forever begin
      @(negedge clock);
`ifdef FIFO_SHOWAHEAD_EN
      if (reset_n && !empty) begin
        if (mq.size() == 0) chk("empty_spurious", empty, 1);
        else chk("q_head", q, mq[0].d);
      end
`else
      if (reset_n && rvalid) begin
        if (sb.size() == 0) chk("rvalid_spurious", rvalid, 0);
        else chk("q", q, sb.pop_front());
      end
`endif
    end
  end

  initial begin
    #1 reset_n = 0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset("reset");
    reset_n = 1;

    // fill to capacity, overflow, drain, underflow
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(i));
    step(1, 0, 0, 8'hEE);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);
    repeat (4) step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);

    // wrap-around with reads trailing writes by 3
    for (int i = 0; i < 43; i++) step(i < 40, i >= 3, 0, 8'(8'h40 + i));
    repeat (4) step(0, 0, 0, 8'h00);

    // sustained write+read at level 8
    for (int i = 0; i < 8; i++) step(1, 0, 0, 8'(8'h80 + i));
    repeat (3) step(0, 0, 0, 8'h00);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 8'($urandom));
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00);
    repeat (4) step(0, 0, 0, 8'h00);

    // thresholds: single-step level upward
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 14; i++) begin
      step(1, 0, 0, 8'(8'hC0 + i));
      step(0, 0, 0, 8'h00);
    end

    // flush at level 9 with a concurrent write
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);
    repeat (3) step(0, 0, 0, 8'h00);
    step(1, 0, 1, 8'hF0);
    repeat (4) step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'hA5);
    repeat (4) step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);

    // reset in the middle of traffic with reads in flight
    for (int i = 0; i < 6; i++) step(1, 0, 0, 8'(8'h60 + i));
    step(0, 1, 0, 8'h00);
    do_reset();

    // randomized traffic with shifting bias and occasional flush
    for (int i = 0; i < 1500; i++) begin
      int wb;
      wb = ((i / 150) % 2 == 0) ? 70 : 30;
      step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < (100 - wb),
           $urandom_range(0, 79) == 0, 8'($urandom));
    end

    for (int i = 0; i < 40; i++) step(0, 1, 0, 8'h00);
    repeat (5) step(0, 0, 0, 8'h00);
`ifndef FIFO_SHOWAHEAD_EN
    chk("sb_drained", sb.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ram.md
# fifo_ram

Parametrised single-clock FIFO built on an inferred block-RAM array (M10K on Cyclone V), generalising the plain dual-port RAMs into a buffered stream with occupancy tracking. It replaces hand-rolled pointer logic around `dualport_ram` in capture and display paths. It adds almost-full and almost-empty thresholds, sticky overflow and underflow flags, synchronous flush, and a compile-time show-ahead (first-word-fall-through) read mode.

## Interface
- `width`, 8: data word width in bits.
- `widthad`, 10: address width; capacity is `2**widthad` words.
- `af_level`, `2**widthad-4`: `almost_full` asserts when `level >= af_level`.
- `ae_level`, 4: `almost_empty` asserts when `level <= ae_level`.

Ports:
- `clock`  in  1  sole clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of pointers, level and flags.
- `wr`  in  1  write request.
- `data`  in  width  write data.
- `rd`  in  1  read request; acts as pop in show-ahead mode.
- `q`  out  width  read data.
- `rvalid`  out  1  `q` holds a newly read word (standard mode only).
- `empty`  out  1  no readable word.
- `full`  out  1  `level == 2**widthad`.
- `almost_full`  out  1  threshold flag.
- `almost_empty`  out  1  threshold flag.
- `level`  out  widthad+1  number of words accepted and not yet popped.
- `overflow`  out  1  sticky: a write was attempted while `full`.
- `underflow`  out  1  sticky: a read was attempted while `empty`.

## Operation
- **Write acceptance:** a write is accepted when `wr && !full`. The word is stored at `wptr` and `wptr` increments modulo `2**widthad`.
- **Write while full:** `wr` while `full` is dropped and sets `overflow`. This applies even if `rd` is accepted in the same cycle.
- **Read acceptance:** a read is accepted when `rd && !empty`. `rptr` increments modulo `2**widthad`.
- **Read while empty:** `rd` while `empty` is ignored and sets `underflow`.
- **Pointers:** both pointers are `widthad` bits and wrap naturally.
- **Level:** `level` is a separate `widthad+1`-bit counter: +1 on an accepted write alone, -1 on an accepted read alone, unchanged when both are accepted.
- **Flag derivation:** `full`, `almost_full`, `almost_empty` and `level` are registered and derived from the post-update count, so they are valid in the cycle after the causing edge.
- **Flush:** clears `wptr`, `rptr`, `level`, `overflow`, `underflow` and `rvalid`, and sets `empty`. RAM contents are left unchanged. Flush has priority over a same-cycle `wr` or `rd`, which are discarded.
- **Reset outputs:** `reset_n` low forces `q=0`, `rvalid=0`, `empty=1`, `full=0`, `almost_full=0`, `almost_empty=1`, `level=0`, `overflow=0`, `underflow=0`, and zeroes both pointers.
- **Reset mid-operation:** asserting `reset_n` during any cycle yields these values immediately and abandons all in-flight data.

## Timing
- **Standard mode, read:** a read accepted at edge N presents the word on `q` with `rvalid=1` after edge N+1. `rvalid` is a one-cycle pulse per accepted read. `q` holds its value otherwise.
- **Standard mode, write to empty:** with a write accepted at edge N into an empty FIFO, `empty` falls after edge N+1. `rd` is therefore honoured from then onward.
- **Back-to-back reads:** one word per cycle.
- **Read-during-write:** reads never target the slot being written in the same cycle.
- **Throughput:** a sustained simultaneous write and read gives one word per cycle in each direction with `level` constant.

## Configuration
- **`FIFO_SHOWAHEAD_EN` defined:** show-ahead mode.
  - An output register prefetches the head word. `q` is valid whenever `empty=0`; `rd` pops it, and the next word appears after the following edge.
  - A write accepted at edge N into an empty FIFO makes `empty` fall after edge N+2 (RAM latency plus the prefetch register). The prefetch register contributes to capacity, so total capacity remains exactly `2**widthad`.
  - `rvalid` is tied to `!empty`.
- **`FIFO_SHOWAHEAD_EN` not defined:** standard registered-read mode as described above. No prefetch register is implemented.

## Test plan
- **Reset:** hold `reset_n` low, then release -> all outputs at reset values; `level=0`, `empty=1`.
- **Fill and drain** (`widthad=4`): write 0x00..0x0F -> `full=1` and `level=16` after the last edge. A 17th write sets `overflow` with `level` still 16. Read all -> `q` sequence 0x00..0x0F, `empty=1`; one more `rd` sets `underflow`.
- **Wrap-around:** 40 sequential writes and reads, offset by 3 words -> data order preserved across pointer wrap; `level` stays in 2..3.
- **Simultaneous write and read** at `level=8`, 20 cycles -> `level` constant at 8; `q` continuous with no gaps; standard mode `rvalid` high every cycle.
- **Thresholds** (`af_level=12`, `ae_level=4`): single-step `level` through 3..13 -> `almost_empty` deasserts at 5; `almost_full` asserts at 12.
- **Flush and show-ahead:** flush at `level=9` with `wr=1` -> `level=0`, `empty=1`, flags cleared, write discarded. Show-ahead build: write 0xA5 at edge N -> `empty=0` and `q=0xA5` after edge N+2, with no `rd` needed.
